// File: rtl/sub_bytes_ecc_corrector.sv
// Two-stage SEC checker for the S-box output path: recomputes the Hamming(12,8) syndrome,
// corrects single-bit errors, and keeps saturating error counters plus a health state.
module sub_bytes_ecc_corrector #(
   parameter int CORR_THRESH = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [11:0]      in_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [3:0]       out_syn,
   output logic             out_corr,
   output logic             out_uncorr,
   input  logic             clr,
   output logic [CNT_W-1:0] corr_count,
   output logic [7:0]       uncorr_count,
   output logic [1:0]       health
);

   typedef enum logic [1:0] {
      H_OK       = 2'd0,
      H_DEGRADED = 2'd1,
      H_FAILED   = 2'd2
   } health_e;

   localparam logic [CNT_W-1:0] THRESH = CNT_W'(CORR_THRESH);

   logic             r_s1_valid;
   logic [11:0]      r_s1_code;
   logic             r_out_valid;
   logic [7:0]       r_out_data;
   logic [3:0]       r_out_syn;
   logic             r_out_corr;
   logic             r_out_uncorr;
   logic [CNT_W-1:0] r_corr_count;
   logic [7:0]       r_uncorr_count;
   health_e          r_health;
   health_e          w_health_nxt;

   logic             w_s2_adv;
   logic             w_load;
   logic [7:0]       w_data;
   logic [3:0]       w_chk;
   logic [3:0]       w_syn;
   logic [7:0]       w_fixed;
   logic             w_corr;
   logic             w_uncorr;
   logic             w_corr_ev;
   logic             w_uncorr_ev;
   logic [CNT_W-1:0] w_corr_inc;
   logic [7:0]       w_uncorr_inc;

   assign w_s2_adv = !r_out_valid || out_ready;
   assign in_ready = !r_s1_valid || w_s2_adv;
   assign w_load   = r_s1_valid && w_s2_adv;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_code  <= '0;
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) r_s1_code <= in_code;
      end
   end

   // Masks select the data bits whose column (3,5,6,7,9,10,11,12) has check bit i set.
   assign w_data = r_s1_code[11:4];
   assign w_chk  = {^(w_data & 8'hF0), ^(w_data & 8'h8E), ^(w_data & 8'h6D), ^(w_data & 8'h5B)};
   assign w_syn  = w_chk ^ r_s1_code[3:0];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_fixed  = w_data;
      w_corr   = 1'b0;
      w_uncorr = 1'b0;
      case (w_syn)
         4'd3:                    begin w_fixed = w_data ^ 8'h01; w_corr = 1'b1; end
         4'd5:                    begin w_fixed = w_data ^ 8'h02; w_corr = 1'b1; end
         4'd6:                    begin w_fixed = w_data ^ 8'h04; w_corr = 1'b1; end
         4'd7:                    begin w_fixed = w_data ^ 8'h08; w_corr = 1'b1; end
         4'd9:                    begin w_fixed = w_data ^ 8'h10; w_corr = 1'b1; end
         4'd10:                   begin w_fixed = w_data ^ 8'h20; w_corr = 1'b1; end
         4'd11:                   begin w_fixed = w_data ^ 8'h40; w_corr = 1'b1; end
         4'd12:                   begin w_fixed = w_data ^ 8'h80; w_corr = 1'b1; end
         4'd1, 4'd2, 4'd4, 4'd8:  w_corr   = 1'b1;
         4'd13, 4'd14, 4'd15:     w_uncorr = 1'b1;
         default:                 ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_syn    <= '0;
         r_out_corr   <= 1'b0;
         r_out_uncorr <= 1'b0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_data   <= w_fixed;
            r_out_syn    <= w_syn;
            r_out_corr   <= w_corr;
            r_out_uncorr <= w_uncorr;
         end
      end
   end

   // Events count only on the load edge, so a stalled word is never recounted.
   assign w_corr_ev    = w_load && w_corr;
   assign w_uncorr_ev  = w_load && w_uncorr;
   assign w_corr_inc   = (&r_corr_count)   ? r_corr_count   : r_corr_count + 1'b1;
   assign w_uncorr_inc = (&r_uncorr_count) ? r_uncorr_count : r_uncorr_count + 1'b1;

   always_comb begin
      w_health_nxt = r_health;
      if (clr) begin
         w_health_nxt = H_OK;
      end else if (w_uncorr_ev) begin
         w_health_nxt = H_FAILED;
      end else if (w_corr_ev) begin
         case (r_health)
            H_OK:       w_health_nxt = H_DEGRADED;
            H_DEGRADED: if (w_corr_inc >= THRESH) w_health_nxt = H_FAILED;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_corr_count   <= '0;
         r_uncorr_count <= '0;
         r_health       <= H_OK;
      end else begin
         r_health <= w_health_nxt;
         if (clr) begin
            r_corr_count   <= '0;
            r_uncorr_count <= '0;
         end else begin
            if (w_corr_ev)   r_corr_count   <= w_corr_inc;
            if (w_uncorr_ev) r_uncorr_count <= w_uncorr_inc;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_syn      = r_out_syn;
   assign out_corr     = r_out_corr;
   assign out_uncorr   = r_out_uncorr;
   assign corr_count   = r_corr_count;
   assign uncorr_count = r_uncorr_count;
   assign health       = r_health;

endmodule
